// File: rtl/apb_arb2.sv
// apb_arb2: two-requester round-robin arbiter in front of a single APB master port.
// Each granted request runs one IDLE -> SETUP -> ACCESS transfer.
// The requester gets a one-cycle ack when pready is seen, or when the ACCESS-phase
// timeout expires; a timeout completes with err=1.
//
// Handshake: a requester raises reqN_valid with stable fields and holds them until
// respN_ack. respN_ack is a single-cycle pulse. respN_rdata and respN_err are valid
// while the ack is high and hold until the next ack. The APB side follows the
// standard SETUP/ACCESS protocol: the slave completes the transfer by driving pready
// during ACCESS.
module apb_arb2 #(
    parameter int TO_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req0_wdata,
    input  logic [31:0] req1_wdata,
    input  logic        req0_write,
    input  logic        req1_write,
    output logic        resp0_ack,
    output logic        resp1_ack,
    output logic [31:0] resp0_rdata,
    output logic [31:0] resp1_rdata,
    output logic        resp0_err,
    output logic        resp1_err,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // The counter only needs to reach TO_CYCLES-1. It is kept at least one bit wide
    // so that TO_CYCLES of 0 or 1 still elaborates.
    localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    state_t         r_state;
    logic           r_ptr;        // requester that wins a tie
    logic           r_gnt;        // requester owning the current transfer
    logic [CW-1:0]  r_to_cnt;
    logic [31:0]    r_paddr;
    logic [31:0]    r_pwdata;
    logic           r_psel;
    logic           r_penable;
    logic           r_pwrite;
    logic           r_ack0;
    logic           r_ack1;
    logic [31:0]    r_rdata0;
    logic [31:0]    r_rdata1;
    logic           r_err0;
    logic           r_err1;

    logic           w_el0;
    logic           w_el1;
    logic           w_any;
    logic           w_gnt;
    logic           w_to_hit;
    logic           w_done;
    logic           w_rsp_err;
    logic [31:0]    w_rsp_rdata;

    // A requester whose ack is high this cycle is still holding valid.
    // It must not be granted again on the same request.
    assign w_el0 = req0_valid & ~r_ack0;
    assign w_el1 = req1_valid & ~r_ack1;
    assign w_any = w_el0 | w_el1;
    // On a tie the pointer decides; otherwise the lone eligible requester wins.
    assign w_gnt = (w_el0 && w_el1) ? r_ptr : w_el1;

    assign w_to_hit    = (TO_CYCLES != 0) && ((int'(r_to_cnt) + 1) == TO_CYCLES);
    assign w_done      = pready || w_to_hit;
    // When pready completes the transfer, the response comes from the slave.
    // When the timeout ends it, the response is forced to an error.
    assign w_rsp_err   = pready ? pslverr : 1'b1;
    assign w_rsp_rdata = (pready && !r_pwrite) ? prdata : 32'd0;

    // Transfer FSM, arbitration pointer, APB outputs and responses, all registered.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b0;
            r_gnt     <= 1'b0;
            r_to_cnt  <= '0;
            r_paddr   <= 32'd0;
            r_pwdata  <= 32'd0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata0  <= 32'd0;
            r_rdata1  <= 32'd0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt    <= w_gnt;
                        r_ptr    <= ~w_gnt;
                        r_paddr  <= w_gnt ? req1_addr  : req0_addr;
                        r_pwdata <= w_gnt ? req1_wdata : req0_wdata;
                        r_pwrite <= w_gnt ? req1_write : req0_write;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_to_cnt  <= '0;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_to_cnt  <= '0;
                        r_state   <= IDLE;
                        if (r_gnt) begin
                            r_ack1   <= 1'b1;
                            r_err1   <= w_rsp_err;
                            r_rdata1 <= w_rsp_rdata;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_err0   <= w_rsp_err;
                            r_rdata0 <= w_rsp_rdata;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + CW'(1);
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign resp0_ack   = r_ack0;
    assign resp1_ack   = r_ack1;
    assign resp0_rdata = r_rdata0;
    assign resp1_rdata = r_rdata1;
    assign resp0_err   = r_err0;
    assign resp1_err   = r_err1;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_arb2.sv
// tb_apb_arb2: directed bench for apb_arb2.
// It covers reset values, a single read, a write with wait states and an error,
// round-robin contention, the ACCESS timeout and a reset in the middle of a transfer.
module tb_apb_arb2;

    logic        pclk;
    logic        preset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_write, req1_write;
    logic        resp0_ack, resp1_ack;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        resp0_err, resp1_err;
    logic [31:0] paddr, pwdata;
    logic        psel, penable, pwrite;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    apb_arb2 #(.TO_CYCLES(16)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_addr   (req0_addr),
        .req1_addr   (req1_addr),
        .req0_wdata  (req0_wdata),
        .req1_wdata  (req1_wdata),
        .req0_write  (req0_write),
        .req1_write  (req1_write),
        .resp0_ack   (resp0_ack),
        .resp1_ack   (resp1_ack),
        .resp0_rdata (resp0_rdata),
        .resp1_rdata (resp1_rdata),
        .resp0_err   (resp0_err),
        .resp1_err   (resp1_err),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and watchdog
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        preset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        preset = 1'b0;
    endtask

    initial begin
        int  n_acc;
        int  n_setup;
        bit  got_ack;
        logic prev_psel;

        preset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_addr = 0;  req1_addr = 0;
        req0_wdata = 0; req1_wdata = 0;
        req0_write = 0; req1_write = 0;
        prdata = 0; pready = 0; pslverr = 0;

        // ---------------- reset values
        do_reset(2);
        check("rst_psel",    psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite",  pwrite, 0);
        check("rst_paddr",   paddr, 0);
        check("rst_pwdata",  pwdata, 0);
        check("rst_ack0",    resp0_ack, 0);
        check("rst_ack1",    resp1_ack, 0);
        check("rst_rdata0",  resp0_rdata, 0);
        check("rst_err1",    resp1_err, 0);
        check("rst_state",   o_dbg_state, 0);

        // ---------------- single read, zero wait states
        req0_valid = 1; req0_addr = 32'h10; req0_write = 0;
        pready = 1; prdata = 32'hDEADBEEF; pslverr = 0;
        tick();  // T+1 SETUP
        check("rd_setup_psel",    psel, 1);
        check("rd_setup_penable", penable, 0);
        check("rd_setup_paddr",   paddr, 32'h10);
        check("rd_setup_pwrite",  pwrite, 0);
        tick();  // T+2 ACCESS
        check("rd_acc_psel",    psel, 1);
        check("rd_acc_penable", penable, 1);
        check("rd_acc_ack0",    resp0_ack, 0);
        tick();  // T+3 ack
        check("rd_ack0",    resp0_ack, 1);
        check("rd_rdata0",  resp0_rdata, 32'hDEADBEEF);
        check("rd_err0",    resp0_err, 0);
        check("rd_end_psel", psel, 0);
        check("rd_ack1",    resp1_ack, 0);
        req0_valid = 0;
        tick();
        check("rd_ack0_pulse", resp0_ack, 0);
        check("rd_rdata_hold", resp0_rdata, 32'hDEADBEEF);
        check("rd_idle_paddr", paddr, 32'h10);

        // ---------------- write with three wait states and a slave error
        pready = 0; pslverr = 0;
        req1_valid = 1; req1_addr = 32'h20; req1_wdata = 32'h55; req1_write = 1;
        tick();  // SETUP
        check("wr_setup_paddr",  paddr, 32'h20);
        check("wr_setup_pwrite", pwrite, 1);
        check("wr_setup_pen",    penable, 0);
        tick();  // first ACCESS cycle
        for (int i = 0; i < 4; i++) begin
            check("wr_acc_psel",   psel, 1);
            check("wr_acc_pen",    penable, 1);
            check("wr_acc_pwdata", pwdata, 32'h55);
            check("wr_acc_noack",  resp1_ack, 0);
            if (i == 3) begin
                pready = 1; pslverr = 1;
            end
            tick();
        end
        check("wr_ack1",   resp1_ack, 1);
        check("wr_err1",   resp1_err, 1);
        check("wr_rdata1", resp1_rdata, 0);
        check("wr_psel",   psel, 0);
        check("wr_ack0",   resp0_ack, 0);
        req1_valid = 0; pready = 0; pslverr = 0;
        tick();

        // ---------------- contention from reset, both requesters keep requesting
        req0_valid = 1; req0_addr = 32'h100; req0_write = 0;
        req1_valid = 1; req1_addr = 32'h200; req1_write = 0;
        pready = 1; prdata = 32'h1234_5678;
        do_reset(2);
        exp_q = {32'h100, 32'h200, 32'h100, 32'h200};
        n_setup = 0;
        prev_psel = psel;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rr_ack_both", resp0_ack & resp1_ack, 0);
            if (psel && !penable) begin
                n_setup++;
                check("rr_psel_gap", prev_psel, 0);
                if (exp_q.size() > 0) check("rr_grant_order", paddr, exp_q.pop_front());
            end
            prev_psel = psel;
        end
        check("rr_n_setup", n_setup, 4);
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();

        // ---------------- timeout with pready tied low
        pready = 0;
        req0_valid = 1; req0_addr = 32'h30; req0_write = 0;
        n_acc = 0; got_ack = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp0_ack) begin
                got_ack = 1;
                break;
            end
            if (psel && penable) n_acc++;
        end
        check("to_got_ack", got_ack, 1);
        check("to_n_access", n_acc, 16);
        check("to_err0",   resp0_err, 1);
        check("to_rdata0", resp0_rdata, 0);
        check("to_psel",   psel, 0);
        check("to_state",  o_dbg_state, 0);
        req0_valid = 0;
        tick();

        // ---------------- reset in the middle of ACCESS
        // A lone req0 grant moves the pointer to req1; the reset must restore it to req0.
        req0_valid = 1; req0_addr = 32'h40; req0_wdata = 32'hA5; req0_write = 1;
        tick();  // SETUP
        tick();  // ACCESS
        tick();  // ACCESS, still waiting
        check("mr_in_access", penable, 1);
        preset = 1'b1;
        tick();
        check("mr_psel",    psel, 0);
        check("mr_penable", penable, 0);
        check("mr_ack0",    resp0_ack, 0);
        check("mr_paddr",   paddr, 0);
        preset = 1'b0;
        req0_addr = 32'h50; req0_write = 0;
        req1_valid = 1; req1_addr = 32'h60; req1_write = 0;
        tick();  // SETUP of the new grant
        check("mr_regrant_psel",  psel, 1);
        check("mr_regrant_paddr", paddr, 32'h50);
        check("mr_no_stale_ack",  resp0_ack, 0);
        pready = 1; prdata = 32'hCAFE_0001;
        tick();  // ACCESS
        tick();  // ack
        check("mr_ack0",   resp0_ack, 1);
        check("mr_rdata0", resp0_rdata, 32'hCAFE_0001);
        req0_valid = 0; req1_valid = 0; pready = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_arb2.md
APB_ARB2 -- requirements
Module: apb_arb2

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 16: maximum ACCESS-phase cycles without pready before the transfer is forced to end; 0 disables the timeout.
REQ-002 SHALL have port pclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port preset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester N has a transfer pending.
REQ-005 SHALL have ports req0_addr, req1_addr  input  32  transfer address.
REQ-006 SHALL have ports req0_wdata, req1_wdata  input  32  write data.
REQ-007 SHALL have ports req0_write, req1_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports resp0_ack, resp1_ack  output  1  one-cycle completion pulse to requester N.
REQ-009 SHALL have ports resp0_rdata, resp1_rdata  output  32  read data, valid while ackN=1.
REQ-010 SHALL have ports resp0_err, resp1_err  output  1  error flag, valid while ackN=1.
REQ-011 SHALL have APB master outputs paddr (32), pwdata (32), psel (1), penable (1) and pwrite (1).
REQ-012 SHALL have APB master inputs prdata (32), pready (1) and pslverr (1).

Function
REQ-013 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-014 IDLE: psel=0, penable=0; if any eligible valid is high, grant one requester, latch its addr/wdata/write into paddr/pwdata/pwrite, then go to SETUP on the next edge.
REQ-015 SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-016 ACCESS: psel=1, penable=1; paddr/pwdata/pwrite held stable; stay in ACCESS while pready=0.
REQ-017 On an edge in ACCESS with pready=1: go to IDLE; register ackN=1 for the granted requester, errN=pslverr, rdataN=prdata for reads and 0 for writes.
REQ-018 Timeout: count ACCESS cycles; when TO_CYCLES consecutive cycles with pready=0 have elapsed, go to IDLE with ackN=1, errN=1, rdataN=0.
REQ-019 ackN SHALL be high for exactly one cycle, coinciding with the following IDLE cycle; rdataN/errN hold until the next ackN.
REQ-020 A requester whose ack is high in the current cycle is ineligible for grant in that cycle.
REQ-021 Arbitration SHALL be round-robin with a priority pointer.
REQ-022 On simultaneous eligible valids, the requester named by the pointer wins.
REQ-023 After each grant, the pointer SHALL move to the other requester; a lone valid always wins regardless of the pointer.
REQ-024 Minimum latency: valid in IDLE cycle T -> SETUP at T+1, ACCESS at T+2, ack at T+3 when pready=1 at T+2; throughput is one transfer per 3 cycles.
REQ-025 Requesters SHALL hold valid and request fields stable until ack; dropping valid before ack is unsupported and does not abort a granted transfer.
REQ-026 psel and penable SHALL never be high together outside ACCESS.
REQ-027 paddr/pwdata/pwrite SHALL hold their last values in IDLE.

Reset
REQ-028 While preset=1 at an edge: FSM -> IDLE; psel, penable, pwrite=0; paddr, pwdata=0; both ack, err and rdata outputs=0; pointer -> req0; timeout counter=0.
REQ-029 Reset asserted during SETUP or ACCESS SHALL abandon the transfer with no ack to the requester; psel=0 from the cycle after the reset edge.

Verification
REQ-030 Single read: req0 read at 0x10, pready=1 immediately, prdata=0xDEADBEEF -> psel 2 cycles, penable 1 cycle, resp0_ack at T+3 with rdata=0xDEADBEEF, err=0.
REQ-031 Wait states with error: req1 write 0x20 data 0x55, pready low for 3 ACCESS cycles then high with pslverr=1 -> ACCESS lasts 4 cycles, pwdata=0x55 stable, resp1_ack with err=1, rdata=0.
REQ-032 Contention: both valid from reset, each re-requesting after ack -> grant order req0, req1, req0, req1; no overlapping psel windows.
REQ-033 Timeout: TO_CYCLES=16, pready tied 0 -> ACCESS exactly 16 cycles, then ack with err=1 and return to IDLE.
REQ-034 Mid-transfer reset: preset pulsed during ACCESS -> no ack, psel=0 next cycle, next simultaneous request granted to req0.
